// File: rtl/sdram_port_arbiter.sv
// Round-robin front end that multiplexes N client ports onto the SDRAM core's single control port.
// Optional request watchdog is compiled in when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 25,
  parameter int WORD_LEN       = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            s_rd,
  input  logic [N_PORTS*WORD_LEN-1:0]   s_wr,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] s_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_write_data,
  output logic [N_PORTS-1:0]            s_rdy,
  output logic [N_PORTS-1:0]            s_rvalid,
  output logic [N_PORTS-1:0]            s_wvalid,
  output logic [N_PORTS-1:0]            s_error,
  output logic [DATA_WIDTH-1:0]         s_read_data,
  output logic                          m_rd,
  output logic [WORD_LEN-1:0]           m_wr,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_write_data,
  input  logic                          m_rdy,
  input  logic                          m_rvalid,
  input  logic                          m_wvalid,
  input  logic [DATA_WIDTH-1:0]         m_read_data,
  input  logic                          m_error,
  output logic                          dbg_state
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   grant;
  logic [N_PORTS-1:0] req;
  logic            any_req;
  logic            done;
  logic            timeout;

  // Handshake: client p transfers when req[p] & s_rdy[p]; that same cycle the core sees
  // (m_rd | |m_wr) & m_rdy. Completions (rvalid/wvalid/error) are single-cycle pulses, no back-pressure.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_req
    assign req[p] = s_rd[p] | (|s_wr[p*WORD_LEN +: WORD_LEN]);
  end

  assign done      = m_rvalid | m_wvalid | m_error;
  assign dbg_state = (state == BUSY);

  // First requesting port at or after rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    sum     = '0;
    cand    = '0;
    grant   = '0;
    any_req = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_PORTS)) sum = sum - (PW+1)'(N_PORTS);
      cand = sum[PW-1:0];
      if (!any_req && req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Held at zero in IDLE, so the first BUSY cycle sees 0 and the Nth BUSY cycle sees N-1.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 16'd1;
  end

  assign timeout = (state == BUSY) && !done && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    s_rdy        = '0;
    s_rvalid     = '0;
    s_wvalid     = '0;
    s_error      = '0;
    s_read_data  = '0;
    m_rd         = 1'b0;
    m_wr         = '0;
    m_addr       = '0;
    m_write_data = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            m_rd         = s_rd[grant];
            m_wr         = s_wr[grant*WORD_LEN +: WORD_LEN];
            m_addr       = s_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
            m_write_data = s_write_data[grant*DATA_WIDTH +: DATA_WIDTH];
            s_rdy[grant] = m_rdy;
            if (m_rdy) begin
              state_nxt  = BUSY;
              owner_nxt  = grant;
              rr_ptr_nxt = (grant == PW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
            end
          end
        end
        BUSY: begin
          s_rvalid[owner] = m_rvalid;
          s_wvalid[owner] = m_wvalid;
          s_error[owner]  = m_error | timeout;
          if (m_rvalid) s_read_data = m_read_data;
          if (done || timeout) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: client drivers, a simple core responder and a completion scoreboard.
// Define SDRAM_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_sdram_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 25;
  localparam int WL = DW / 8;
  localparam int TO = 8;
  localparam int EW = 38;  // {port[3:0], kind[1:0], data[31:0]}; kind 0=read 1=write 2=error

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_rd;
  logic [N*WL-1:0] s_wr;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_write_data;
  logic [N-1:0]    s_rdy, s_rvalid, s_wvalid, s_error;
  logic [DW-1:0]   s_read_data;
  logic            m_rd;
  logic [WL-1:0]   m_wr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_write_data;
  logic            m_rdy, m_rvalid, m_wvalid, m_error;
  logic [DW-1:0]   m_read_data;
  logic            dbg_state;

  sdram_port_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_LEN(WL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_write_data(s_write_data),
    .s_rdy(s_rdy), .s_rvalid(s_rvalid), .s_wvalid(s_wvalid), .s_error(s_error),
    .s_read_data(s_read_data),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_write_data(m_write_data),
    .m_rdy(m_rdy), .m_rvalid(m_rvalid), .m_wvalid(m_wvalid), .m_read_data(m_read_data),
    .m_error(m_error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // client state
  int            pend [N];
  logic [N-1:0]  c_rd;
  logic [N-1:0]  acc;
  logic [WL-1:0] c_strb [N];
  logic [AW-1:0] c_addr [N];
  logic [DW-1:0] c_data [N];

  // core responder state
  bit            core_busy, core_hang, force_rv, rdata_forced;
  int            core_cnt, lat_min, lat_max, rdy_pct, err_pct;
  logic [1:0]    core_kind;
  logic [DW-1:0] core_rdata, rdata_force;

  // reference model and scoreboard
  bit            busy_m;
  int            rr_m, owner_m, busy_cyc, cyc, to_hits;
  int            grant_log[$], acc_cyc_log[$], cpl_log[$];
  logic [EW-1:0] exp_q[$];

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_txn(input int p);
    c_rd[p]   = 1'($urandom_range(0, 1));
    c_strb[p] = WL'($urandom_range(1, (1 << WL) - 1));
    c_addr[p] = AW'($urandom);
    c_data[p] = $urandom;
  endtask

  task automatic drive_clients();
    for (int p = 0; p < N; p++) begin
      if (pend[p] > 0) begin
        s_rd[p]                = c_rd[p];
        s_wr[p*WL +: WL]       = c_rd[p] ? WL'(0) : c_strb[p];
        s_addr[p*AW +: AW]     = c_addr[p];
        s_write_data[p*DW +: DW] = c_data[p];
      end else begin
        s_rd[p]                = 1'b0;
        s_wr[p*WL +: WL]       = '0;
        s_addr[p*AW +: AW]     = '0;
        s_write_data[p*DW +: DW] = '0;
      end
    end
  endtask

  task automatic set_rdy(input int pct);
    rdy_pct = pct;
    m_rdy   = (pct >= 100);
  endtask

  // One clock: check at negedge, then drive core and clients just after posedge.
  task automatic step();
    logic [N-1:0]  req, oh;
    logic [EW-1:0] e;
    logic [1:0]    kind;
    logic [DW-1:0] rdata;
    int            g, ep, c;
    bit            strobe;
    @(negedge clk);
    cyc++;
    strobe = m_rvalid | m_wvalid | m_error;
    for (int p = 0; p < N; p++) req[p] = (pend[p] > 0);
    if (rst) begin
      check("rst_s_rdy", s_rdy, '0);
      check("rst_s_rvalid", s_rvalid, '0);
      check("rst_s_wvalid", s_wvalid, '0);
      check("rst_s_error", s_error, '0);
      check("rst_s_read_data", s_read_data, '0);
      check("rst_m_rd", m_rd, 1'b0);
      check("rst_m_wr", m_wr, '0);
      busy_m = 1'b0;
      rr_m   = 0;
      exp_q.delete();
      if (strobe) core_busy = 1'b0;
    end else if (!busy_m) begin
      check("idle_state", dbg_state, 1'b0);
      check("idle_s_rvalid", s_rvalid, '0);
      check("idle_s_wvalid", s_wvalid, '0);
      check("idle_s_error", s_error, '0);
      check("idle_s_read_data", s_read_data, '0);
      if (strobe) core_busy = 1'b0;
      if (req != '0) begin
        g = -1;
        for (int i = 0; i < N; i++) begin
          c = (rr_m + i) % N;
          if (g < 0 && req[c]) g = c;
        end
        oh = N'(1) << g;
        check("grant_m_rd", m_rd, c_rd[g]);
        check("grant_m_wr", m_wr, c_rd[g] ? WL'(0) : c_strb[g]);
        check("grant_m_addr", m_addr, c_addr[g]);
        check("grant_m_wdata", m_write_data, c_data[g]);
        check("grant_s_rdy", s_rdy, m_rdy ? oh : '0);
        if (m_rdy) begin
          acc[g]   = 1'b1;
          busy_m   = 1'b1;
          owner_m  = g;
          busy_cyc = 0;
          rr_m     = (g + 1) % N;
          grant_log.push_back(g);
          acc_cyc_log.push_back(cyc);
          kind  = c_rd[g] ? 2'd0 : 2'd1;
          if ($urandom_range(0, 99) < err_pct) kind = 2'd2;
          rdata = rdata_forced ? rdata_force : $urandom;
          exp_q.push_back({4'(g), kind, (kind == 2'd0) ? rdata : DW'(0)});
          core_busy  = 1'b1;
          core_kind  = kind;
          core_rdata = rdata;
          core_cnt   = $urandom_range(lat_max, lat_min);
        end
      end else begin
        check("idle_m_rd", m_rd, 1'b0);
        check("idle_m_wr", m_wr, '0);
        check("idle_s_rdy", s_rdy, '0);
      end
    end else begin
      busy_cyc++;
      check("busy_state", dbg_state, 1'b1);
      check("busy_m_rd", m_rd, 1'b0);
      check("busy_m_wr", m_wr, '0);
      check("busy_m_addr", m_addr, '0);
      check("busy_m_wdata", m_write_data, '0);
      check("busy_s_rdy", s_rdy, '0);
      if (strobe) begin
        core_busy = 1'b0;
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          e    = exp_q.pop_front();
          ep   = int'(e[37:34]);
          kind = e[33:32];
          oh   = N'(1) << ep;
          check("cpl_s_rvalid", s_rvalid, (kind == 2'd0) ? oh : '0);
          check("cpl_s_wvalid", s_wvalid, (kind == 2'd1) ? oh : '0);
          check("cpl_s_error", s_error, (kind == 2'd2) ? oh : '0);
          check("cpl_s_read_data", s_read_data, e[DW-1:0]);
        end
        busy_m = 1'b0;
        cpl_log.push_back(cyc);
      end
`ifdef SDRAM_ARB_TIMEOUT_EN
      else if (busy_cyc == TO) begin
        oh = N'(1) << owner_m;
        check("to_s_error", s_error, oh);
        check("to_s_rvalid", s_rvalid, '0);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        busy_m = 1'b0;
        to_hits++;
      end
`endif
      else begin
        check("busy_s_rvalid", s_rvalid, '0);
        check("busy_s_wvalid", s_wvalid, '0);
        check("busy_s_error", s_error, '0);
        check("busy_s_read_data", s_read_data, '0);
      end
    end

    @(posedge clk);
    #1;
    m_rvalid    = force_rv;
    m_wvalid    = 1'b0;
    m_error     = 1'b0;
    m_read_data = $urandom;  // garbage unless a read completes
    if (core_busy && !core_hang) begin
      if (core_cnt == 0) begin
        case (core_kind)
          2'd0: begin m_rvalid = 1'b1; m_read_data = core_rdata; end
          2'd1: m_wvalid = 1'b1;
          default: m_error = 1'b1;
        endcase
      end else begin
        core_cnt--;
      end
    end
    m_rdy = ($urandom_range(0, 99) < rdy_pct);
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        acc[p] = 1'b0;
        pend[p]--;
        if (pend[p] > 0) load_txn(p);
      end
    end
    drive_clients();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((any_pend() || busy_m) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", any_pend() || busy_m, 1'b0);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy_m && n < budget) begin
      step();
      n++;
    end
    check("wait_busy_timeout", busy_m, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1; force_rv = 1'b1; core_busy = 1'b0; core_hang = 1'b0; rdata_forced = 1'b0;
    rdata_force = '0; core_cnt = 0; core_kind = '0; core_rdata = '0;
    lat_min = 0; lat_max = 0; err_pct = 0; busy_m = 1'b0; rr_m = 0; owner_m = 0;
    busy_cyc = 0; cyc = 0; to_hits = 0; acc = '0; c_rd = '0;
    for (int p = 0; p < N; p++) begin
      pend[p] = 0; c_strb[p] = '0; c_addr[p] = '0; c_data[p] = '0;
    end
    m_rvalid = 1'b1; m_wvalid = 1'b0; m_error = 1'b0; m_read_data = $urandom;
    set_rdy(0);
    drive_clients();

    // reset with a stray completion strobe present
    do_reset(2);
    force_rv = 1'b0;
    m_rvalid = 1'b0;

    // single read from port 2
    set_rdy(100);
    lat_min = 2; lat_max = 2;
    rdata_forced = 1'b1; rdata_force = 32'hDEAD_BEEF;
    pend[2] = 1; c_rd[2] = 1'b1; c_addr[2] = 25'h000_0400; c_data[2] = $urandom; c_strb[2] = '0;
    drive_clients();
    run_until_done(50);
    step();
    rdata_forced = 1'b0;

    // round robin across ports 0,1,3 from a fresh pointer
    do_reset(2);
    grant_log.delete();
    lat_min = 0; lat_max = 0;
    foreach (exp_order[i]) if (i < 3) begin pend[exp_order[i]] = 2; load_txn(exp_order[i]); end
    drive_clients();
    run_until_done(100);
    check("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), grant_log[i], exp_order[i]);

    // backpressure on a port 1 full-word write
    set_rdy(0);
    lat_min = 1; lat_max = 1;
    pend[1] = 1; c_rd[1] = 1'b0; c_strb[1] = 4'hF; c_addr[1] = AW'($urandom); c_data[1] = $urandom;
    drive_clients();
    repeat (5) step();
    check("bp_not_accepted", busy_m, 1'b0);
    set_rdy(100);
    run_until_done(50);

    // busy isolation: port 3 waits while port 0 is outstanding
    grant_log.delete(); acc_cyc_log.delete(); cpl_log.delete();
    lat_min = 4; lat_max = 4;
    pend[0] = 1; c_rd[0] = 1'b1; c_addr[0] = AW'($urandom);
    drive_clients();
    wait_busy(20);
    pend[3] = 1; load_txn(3);
    drive_clients();
    run_until_done(60);
    check("iso_count", grant_log.size(), 2);
    check("iso_first", grant_log[0], 0);
    check("iso_second", grant_log[1], 3);
    check("iso_regrant_cycle", acc_cyc_log[1], cpl_log[0] + 1);

    // random traffic with errors, backpressure and variable latency
    err_pct = 15; lat_min = 0; lat_max = 3; set_rdy(70);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < N; p++) begin
        pend[p] = $urandom_range(0, 6);
        if (pend[p] > 0) load_txn(p);
      end
      drive_clients();
      run_until_done(2000);
    end
    err_pct = 0; set_rdy(100);

    // reset while a read is outstanding; the late completion must go nowhere
    core_hang = 1'b1; lat_min = 0; lat_max = 0;
    pend[2] = 1; c_rd[2] = 1'b1; c_addr[2] = AW'($urandom);
    drive_clients();
    wait_busy(20);
    repeat (2) step();
    do_reset(2);
    core_hang = 1'b0;
    repeat (4) step();

`ifdef SDRAM_ARB_TIMEOUT_EN
    // watchdog: hung read on port 0, error on the 8th busy cycle, late rvalid dropped
    core_hang = 1'b1; to_hits = 0;
    pend[0] = 1; c_rd[0] = 1'b1; c_addr[0] = AW'($urandom);
    drive_clients();
    wait_busy(20);
    repeat (TO + 2) step();
    check("to_fired", to_hits, 1);
    core_hang = 1'b0;
    repeat (4) step();
`endif

    check("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Multi-client front end that sits directly upstream of the SDRAM core's control port.
- Arbitrates N client request ports round-robin onto the core's single rd/wr/addr/write_data/rdy handshake.
- Tracks the one outstanding transaction and routes its rvalid/wvalid/read_data/error back to the issuing client only.
- Blocking, single-outstanding: matches the core, which returns to idle only after completing each access.

Parameters:
- N_PORTS, 4: number of client ports (2..8).
- DATA_WIDTH, 32: data width (8/16/32), must equal the core's.
- ADDR_WIDTH, 25: byte address width, must equal the core's.
- WORD_LEN, DATA_WIDTH/8: byte strobes per word.
- TIMEOUT_CYCLES, 64: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_rd  in  N_PORTS  per-port read request.
- s_wr  in  N_PORTS*WORD_LEN  per-port write byte strobes; port p uses slice [p*WORD_LEN +: WORD_LEN].
- s_addr  in  N_PORTS*ADDR_WIDTH  per-port byte address.
- s_write_data  in  N_PORTS*DATA_WIDTH  per-port write data.
- s_rdy  out  N_PORTS  request accepted this cycle when s_rdy[p] & request.
- s_rvalid  out  N_PORTS  one-cycle read completion.
- s_wvalid  out  N_PORTS  one-cycle write completion.
- s_error  out  N_PORTS  one-cycle error completion.
- s_read_data  out  DATA_WIDTH  shared read data; valid only with an s_rvalid bit, zero otherwise.
- m_rd  out  1  read request to core.
- m_wr  out  WORD_LEN  write strobes to core.
- m_addr  out  ADDR_WIDTH  address to core.
- m_write_data  out  DATA_WIDTH  write data to core.
- m_rdy  in  1  core ready.
- m_rvalid  in  1  core read completion.
- m_wvalid  in  1  core write completion.
- m_read_data  in  DATA_WIDTH  core read data.
- m_error  in  1  core error.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Port request: req[p] = s_rd[p] | (|s_wr[p]). Clients hold request and payload stable until accepted. A port asserting rd and wr together is illegal; the arbiter forwards it unmodified.
- Reset values: state IDLE, rr_ptr=0, owner=0. All s_rdy/s_rvalid/s_wvalid/s_error = 0, s_read_data = 0. m_rd = 0, m_wr = 0, m_addr = 0, m_write_data = 0.
- States: IDLE, BUSY.
- IDLE, grant selection (combinational):
  - grant = first p with req[p], searching rr_ptr, rr_ptr+1, … modulo N_PORTS.
  - If any req, the granted port's rd/wr/addr/write_data drive m_* in the same cycle (zero latency); otherwise all m_* = 0.
  - s_rdy[grant] = m_rdy; all other s_rdy = 0.
- IDLE, accept = any req & m_rdy:
  - Next cycle: state = BUSY, owner = grant, rr_ptr = (grant+1) mod N_PORTS (wraps N_PORTS-1 -> 0).
  - No accept: rr_ptr unchanged.
- BUSY:
  - m_rd = 0, m_wr = 0, m_addr/m_write_data = 0; all s_rdy = 0.
  - On m_rvalid: s_rvalid[owner] = 1 and s_read_data = m_read_data, same cycle (combinational).
  - On m_wvalid: s_wvalid[owner] = 1, same cycle.
  - On m_error: s_error[owner] = 1, same cycle.
  - Any of these: next state IDLE.
  - Completion and a new grant never overlap, so the minimum re-accept is the cycle after completion.
- Completion strobes outside BUSY are ignored; nothing is routed.
- rst mid-BUSY: return to IDLE, in-flight completion discarded. The core shares rst, so this is consistent.
- Fairness: a continuously requesting port waits at most N_PORTS-1 transactions.

Optional Feature:
- Macro SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit watchdog cleared on entering BUSY, incremented each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no completion: s_error[owner] pulses for one cycle, state returns to IDLE.
  - A completion arriving in the same cycle as the timeout takes precedence; no error.
  - Late completions after a timeout are dropped (arbiter in IDLE).
- Not defined: no counter; BUSY waits indefinitely; s_error reflects m_error only.

Test Plan:
- Reset: assert rst 2 cycles -> all s_* outputs 0; m_rd=0, m_wr=0.
- Single read: port 2 s_rd=1, s_addr=0x0000400, m_rdy=1 -> m_addr=0x0000400 same cycle, s_rdy[2]=1. Core returns m_rvalid with m_read_data=0xDEADBEEF -> s_rvalid=4'b0100, s_read_data=0xDEADBEEF for one cycle; s_read_data=0 the next cycle.
- Round robin: ports 0,1,3 all request continuously -> grant order 0,1,3,0,1,3; rr_ptr wraps 3->0.
- Backpressure: port 1 write s_wr=4'hF, m_rdy=0 for 5 cycles -> m_wr=4'hF held, s_rdy[1]=0 throughout. m_rdy=1 -> accepted; after m_wvalid, s_wvalid[1]=1.
- Busy isolation: while BUSY with owner 0, port 3 requests -> m_rd/m_wr stay 0 and s_rdy[3]=0 until m_rvalid; port 3 is granted the cycle after.
- SDRAM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: port 0 read accepted, no completion -> s_error[0]=1 on the 8th BUSY cycle, IDLE next. A late m_rvalid produces no s_rvalid.
